// File: rtl/cineraria_led_pkg.sv
// rtl/cineraria_led_pkg.sv - shared constants for the LED scan controller
//
// Purpose: register map, CTRL field positions, CTRL reset value and the
//          hex-to-7-segment glyph table used by the scan core and decoder.
// Ports:   none (package).

package cineraria_led_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_HEX_BIT    = 1;
  localparam int CTRL_BRIGHT_LSB = 8;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0F00;

  // Segment order per glyph is g..a (bit6..bit0); entry 15 is listed first.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/cineraria_core_led_hex7.sv
// rtl/cineraria_core_led_hex7.sv - combinational 4-bit to 7-segment decoder
//
// Purpose: maps a nibble to its standard 0-F glyph (active-high, g..a).
// Ports:
//   value    in  4  nibble to decode
//   segments out 7  glyph, bit6 = g ... bit0 = a

module cineraria_core_led_hex7
  import cineraria_led_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segments
);

  assign segments = HEX_GLYPH[value];

endmodule

// File: rtl/cineraria_core_led_scan.sv
// rtl/cineraria_core_led_scan.sv - multiplexed 7-segment LED scan controller
//
// Purpose: Avalon-MM register slave driving up to four multiplexed digits
//          with per-slot guard blanking, 16-step PWM brightness and a
//          per-digit blink mask.
// Configuration: define LED_SCAN_HEXDEC_EN to add CTRL.HEX and the hex
//          glyph decoder; without it the raw digit byte is always shown.
// Ports:
//   clk         in  1       clock, rising edge
//   reset       in  1       synchronous, active-high
//   address     in  2       register select (DATA, CTRL, BLINK, STATUS)
//   chipselect  in  1       bus select
//   write_n     in  1       write strobe, active-low
//   writedata   in  32      write data
//   readdata    out 32      read data, combinational from address
//   seg_n       out 8       segments, active-low, bit7 = DP
//   dig_n       out DIGITS  digit enables, active-low

module cineraria_core_led_scan
  import cineraria_led_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 5000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [7:0]        seg_n,
  output logic [DIGITS-1:0] dig_n
);

  localparam int PW = $clog2(PRESCALE);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);
  localparam logic [1:0]    IDX_MAX   = 2'(DIGITS - 1);
  localparam logic [31:0]   DATA_MASK = (DIGITS >= 4) ? 32'hFFFF_FFFF
                                      : ((32'h1 << (8 * DIGITS)) - 32'h1);

  logic [31:0]       data_q;
  logic              en_q;
  logic [3:0]        bright_q;
  logic [DIGITS-1:0] blink_q;
  logic              hex_rd;

  logic [PW-1:0]     presc_q;
  logic [1:0]        idx_q;
  logic [3:0]        pwm_q;
  logic [FW-1:0]     frame_q;
  logic              phase_q;

  logic [7:0]        seg_n_q;
  logic [DIGITS-1:0] dig_n_q;

  logic              wr;
  logic              scan_stop;
  logic [7:0]        cur_byte;
  logic [7:0]        pattern;
  logic [3:0]        blink_ext;
  logic [3:0]        dig_onehot;
  logic              drive_on;

  assign wr = chipselect & ~write_n;
  // A CTRL write with EN=0 both disables and zeroes the scan on the same edge.
  assign scan_stop = wr && (address == ADDR_CTRL) && !writedata[CTRL_EN_BIT];

  // Register file
`ifdef LED_SCAN_HEXDEC_EN
  logic hex_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= CTRL_RESET[CTRL_HEX_BIT];
    end else if (wr && address == ADDR_CTRL) begin
      hex_q <= writedata[CTRL_HEX_BIT];
    end
  end
  assign hex_rd = hex_q;
`else
  assign hex_rd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      en_q     <= CTRL_RESET[CTRL_EN_BIT];
      bright_q <= CTRL_RESET[CTRL_BRIGHT_LSB +: 4];
      blink_q  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:  data_q  <= writedata & DATA_MASK;
        ADDR_CTRL: begin
          en_q     <= writedata[CTRL_EN_BIT];
          bright_q <= writedata[CTRL_BRIGHT_LSB +: 4];
        end
        ADDR_BLINK: blink_q <= writedata[DIGITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = data_q;
      ADDR_CTRL:   readdata = {20'd0, bright_q, 6'd0, hex_rd, en_q};
      ADDR_BLINK:  readdata = 32'(blink_q);
      ADDR_STATUS: readdata = {29'd0, phase_q, idx_q};
      default:     readdata = '0;
    endcase
  end

  // Scan counters: prescaler -> digit index -> frame counter -> blink phase.
  always_ff @(posedge clk) begin
    if (reset || scan_stop) begin
      presc_q <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (en_q) begin
      pwm_q <= pwm_q + 4'd1;
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
        if (idx_q == IDX_MAX) begin
          idx_q <= '0;
          if (frame_q == FRAME_MAX) begin
            frame_q <= '0;
            phase_q <= ~phase_q;
          end else begin
            frame_q <= frame_q + FW'(1);
          end
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Digit pattern selection
  assign cur_byte  = data_q[{idx_q, 3'b000} +: 8];
  assign blink_ext = 4'(blink_q);

`ifdef LED_SCAN_HEXDEC_EN
  logic [6:0] glyph;
  cineraria_core_led_hex7 u_hex7 (
    .value    (cur_byte[3:0]),
    .segments (glyph)
  );
  assign pattern = hex_q ? {cur_byte[7], glyph} : cur_byte;
`else
  assign pattern = cur_byte;
`endif

  assign dig_onehot = 4'b0001 << idx_q;
  assign drive_on   = en_q && (presc_q >= GUARD_V) && (pwm_q <= bright_q)
                      && !(blink_ext[idx_q] && phase_q);

  // Segments and digit enables share one register stage so they switch together.
  always_ff @(posedge clk) begin
    if (reset || scan_stop) begin
      seg_n_q <= 8'hFF;
      dig_n_q <= '1;
    end else if (drive_on) begin
      seg_n_q <= ~pattern;
      dig_n_q <= ~dig_onehot[DIGITS-1:0];
    end else begin
      seg_n_q <= 8'hFF;
      dig_n_q <= '1;
    end
  end

  assign seg_n = seg_n_q;
  assign dig_n = dig_n_q;

endmodule

// File: tb/tb_cineraria_core_led_scan.sv
// tb/tb_cineraria_core_led_scan.sv - self-checking bench for the LED scan controller

module tb_cineraria_core_led_scan;

  localparam int DIGITS    = 4;
  localparam int PRESCALE  = 8;
  localparam int GUARD     = 1;
  localparam int BLINK_DIV = 2;
`ifdef LED_SCAN_HEXDEC_EN
  localparam bit HAS_HEX = 1'b1;
`else
  localparam bit HAS_HEX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  always #5 clk = ~clk;

  cineraria_core_led_scan #(
    .DIGITS    (DIGITS),
    .PRESCALE  (PRESCALE),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: registers plus t = enabled cycles since scan start.
  logic [31:0] m_data   = '0;
  logic [31:0] m_blink  = '0;
  logic        m_en     = 1'b0;
  logic        m_hex    = 1'b0;
  logic [3:0]  m_bright = 4'hF;
  int          t        = 0;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int m_idx();
    return (t / PRESCALE) % DIGITS;
  endfunction

  function automatic logic m_phase();
    return ((t / (PRESCALE * DIGITS)) / BLINK_DIV) % 2 == 1;
  endfunction

  function automatic logic [11:0] m_pins();
    int         idx;
    logic [7:0] b;
    logic [7:0] pat;
    logic [3:0] oh;
    idx = m_idx();
    b   = m_data[8*idx +: 8];
    pat = b;
    if (HAS_HEX && m_hex) pat = {b[7], glyph(b[3:0])};
    oh  = 4'b0001 << idx;
    if (m_en && (t % PRESCALE) >= GUARD && (t % 16) <= int'(m_bright)
        && !(m_blink[idx] && m_phase()))
      return {~pat, ~oh};
    return 12'hFFF;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {20'd0, m_bright, 6'd0, m_hex, m_en};
      2'd2:    return m_blink;
      default: return {29'd0, m_phase(), 2'(m_idx())};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, model the edge, check pins and readdata at next negedge.
  task automatic step(input logic wr, input logic [1:0] a, input logic [31:0] wd, input logic rst);
    logic [11:0] exp;
    reset      = rst;
    chipselect = wr;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    exp = m_pins();
    if (rst || (wr && a == 2'd1 && !wd[0])) exp = 12'hFFF;
    @(posedge clk);
    if (rst) begin
      m_data = '0; m_blink = '0; m_en = 1'b0; m_hex = 1'b0; m_bright = 4'hF; t = 0;
    end else begin
      if (wr && a == 2'd1 && !wd[0]) t = 0;
      else if (m_en) t++;
      if (wr) begin
        case (a)
          2'd0: m_data = wd;
          2'd1: begin
            m_en     = wd[0];
            m_hex    = HAS_HEX ? wd[1] : 1'b0;
            m_bright = wd[11:8];
          end
          2'd2: m_blink = wd & 32'hF;
          default: ;
        endcase
      end
    end
    @(negedge clk);
    check("seg_n", 32'(seg_n), 32'(exp[11:4]));
    check("dig_n", 32'(dig_n), 32'(exp[3:0]));
    check("readdata", readdata, m_read(a));
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0]  dseq[4];
    logic [7:0]  sseq[4];
    int          cnt;
    int          cnt_b;
    int          last_tog;
    int          n_tog;
    int          gap_bad;
    logic        prev_ph;
    logic [31:0] wd;

    dseq = '{4'hE, 4'hD, 4'hB, 4'h7};
    sseq = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};

    vecs[0] = '{2'd0, 32'h3F065B4F, 32'h3F065B4F};
    vecs[1] = '{2'd2, 32'hFFFFFFFF, 32'h0000000F};
    vecs[2] = '{2'd1, 32'hFFFFF0FE, HAS_HEX ? 32'h2 : 32'h0};
    vecs[3] = '{2'd3, 32'hFFFFFFFF, 32'h00000000};
    vecs[4] = '{2'd1, 32'h00000A00, 32'h00000A00};
    vecs[5] = '{2'd2, 32'h00000000, 32'h00000000};
    vecs[6] = '{2'd0, 32'h12345678, 32'h12345678};
    vecs[7] = '{2'd1, 32'h00000F00, 32'h00000F00};

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    @(negedge clk);
    step(1'b0, 2'd1, 32'h0, 1'b1);
    step(1'b0, 2'd1, 32'h0, 1'b1);

    // Reset state
    check("rst_seg", 32'(seg_n), 32'hFF);
    check("rst_dig", 32'(dig_n), 32'hF);
    check("rst_ctrl", readdata, 32'h00000F00);

    // Register write/read table
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].wd, 1'b0);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // Scan sequence: digit order, guard blank, raw patterns
    step(1'b1, 2'd0, 32'h3F065B4F, 1'b0);
    step(1'b1, 2'd1, 32'h00000F01, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 2'd3, 32'h0, 1'b0);
      if ((k - 1) % 8 == 0) begin
        check($sformatf("scan%0d_dig", k), 32'(dig_n), 32'hF);
        check($sformatf("scan%0d_seg", k), 32'(seg_n), 32'hFF);
      end else begin
        check($sformatf("scan%0d_dig", k), 32'(dig_n), 32'(dseq[(k - 1) / 8]));
        check($sformatf("scan%0d_seg", k), 32'(seg_n), 32'(sseq[(k - 1) / 8]));
      end
    end

    // Disable mid-slot, then restart from digit 0
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 32'h0, 1'b0);
    step(1'b1, 2'd1, 32'h00000F00, 1'b0);
    check("stop_seg", 32'(seg_n), 32'hFF);
    check("stop_dig", 32'(dig_n), 32'hF);
    step(1'b0, 2'd3, 32'h0, 1'b0);
    check("stop_status", readdata, 32'h0);
    step(1'b1, 2'd1, 32'h00000F01, 1'b0);
    step(1'b0, 2'd3, 32'h0, 1'b0);
    check("restart_blank", 32'(dig_n), 32'hF);
    step(1'b0, 2'd3, 32'h0, 1'b0);
    check("restart_dig", 32'(dig_n), 32'hE);
    check("restart_status", readdata, 32'h0);

    // Brightness 3: drive on only for PWM counts 0..3, minus guard cycles
    step(1'b1, 2'd1, 32'h00000F00, 1'b0);
    step(1'b1, 2'd1, 32'h00000301, 1'b0);
    cnt = 0;
    for (int k = 0; k < 128; k++) begin
      step(1'b0, 2'd1, 32'h0, 1'b0);
      if (dig_n != 4'hF) cnt++;
    end
    check("pwm_on_count", 32'(cnt), 32'd24);

    // Blink digit 1: phase toggles every 64 clk, digit 1 dark while phase=1
    step(1'b1, 2'd1, 32'h00000F00, 1'b0);
    step(1'b1, 2'd1, 32'h00000F01, 1'b0);
    step(1'b1, 2'd2, 32'h00000002, 1'b0);
    prev_ph = 1'b0; last_tog = -1; n_tog = 0; gap_bad = 0; cnt = 0; cnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 2'd3, 32'h0, 1'b0);
      if (readdata[2] != prev_ph) begin
        if (last_tog >= 0 && i - last_tog != 64) gap_bad++;
        last_tog = i;
        n_tog++;
        prev_ph = readdata[2];
      end
      if (dig_n == 4'hD) begin
        if (readdata[2]) cnt++;
        else cnt_b++;
      end
    end
    check("blink_toggles", 32'(n_tog), 32'd3);
    check("blink_gap", 32'(gap_bad), 32'd0);
    check("blink_dark", 32'(cnt), 32'd0);
    check("blink_lit", 32'(cnt_b != 0), 32'd1);

`ifdef LED_SCAN_HEXDEC_EN
    step(1'b1, 2'd1, 32'h00000F00, 1'b0);
    step(1'b1, 2'd2, 32'h00000000, 1'b0);
    step(1'b1, 2'd0, 32'h0000810A, 1'b0);
    step(1'b1, 2'd1, 32'h00000F03, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b0);
    check("hex_a_seg", 32'(seg_n), 32'h88);
    for (int k = 0; k < 8; k++) step(1'b0, 2'd0, 32'h0, 1'b0);
    check("hex_1dp_seg", 32'(seg_n), 32'h79);
    check("hex_1dp_dig", 32'(dig_n), 32'hD);
`endif

    // Reset overrides a concurrent write
    step(1'b1, 2'd0, 32'hDEADBEEF, 1'b1);
    check("rst_over_wr", readdata, 32'h0);
    check("rst_over_seg", 32'(seg_n), 32'hFF);

    // Randomized traffic against the model
    step(1'b1, 2'd1, 32'h00000F01, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(1'b0, 2'($urandom_range(0, 3)), 32'h0, 1'b1);
      end else if ($urandom_range(0, 5) == 0) begin
        wd = $urandom;
        if (wd[1:0] == 2'd1) wd[0] = ($urandom_range(0, 15) != 0);
        step(1'b1, 2'($urandom_range(0, 3)), wd, 1'b0);
      end else begin
        step(1'b0, 2'($urandom_range(0, 3)), 32'h0, 1'b0);
      end
      if (!m_en && $urandom_range(0, 3) == 0)
        step(1'b1, 2'd1, {$urandom} | 32'h1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cineraria_core_led_scan.md
CINERARIA_CORE_LED_SCAN -- requirements
Module: cineraria_core_led_scan

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..4); DATA holds 8 bits per digit.
REQ-002 Parameter PRESCALE, default 5000, clk cycles per digit slot (>= GUARD+2).
REQ-003 Parameter GUARD, default 16, blanking cycles at the start of each slot.
REQ-004 Parameter BLINK_DIV, default 128, full scan frames per blink half-period.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  2  Avalon-MM register select.
REQ-008 chipselect  in  1  Avalon-MM select.
REQ-009 write_n  in  1  Avalon-MM write strobe, active-low.
REQ-010 writedata  in  32  Avalon-MM write data.
REQ-011 readdata  out  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-012 seg_n  out  8  segment drive, active-low, bit7 = DP, bits6:0 = g..a.
REQ-013 dig_n  out  DIGITS  digit select, active-low, one-hot-low or all-high.

Function
REQ-014 Registers: addr0 DATA[31:0] (digit i = bits 8i+7:8i); addr1 CTRL (bit0 EN, bit1 HEX, bits11:8 BRIGHT); addr2 BLINK[DIGITS-1:0] per-digit blink mask; addr3 STATUS read-only (bits1:0 current digit index, bit2 blink phase).
REQ-015 A write (chipselect & ~write_n) updates the addressed register at the next clk edge; writes to addr3 and to unimplemented bits are ignored; unimplemented bits read 0.
REQ-016 Prescaler counts 0..PRESCALE-1 when EN=1; at PRESCALE-1 it wraps to 0 and digit index advances, wrapping DIGITS-1 -> 0.
REQ-017 Each digit index wrap to 0 counts one frame; after BLINK_DIV frames the blink phase toggles and the frame counter clears.
REQ-018 4-bit PWM counter free-runs while EN=1; drive is on when pwm_cnt <= BRIGHT (BRIGHT=15 always on, BRIGHT=0 1/16 duty).
REQ-019 Current digit drive active only when: EN=1, prescaler >= GUARD, PWM on, and not (blink mask bit set AND blink phase=1); otherwise seg_n=8'hFF and dig_n all ones.
REQ-020 When active, dig_n bit[index]=0, others 1; seg_n = ~pattern of current digit.
REQ-021 seg_n and dig_n are registered: one clk latency from prescaler/PWM state to pins; both change on the same edge (no glitch between them).
REQ-022 Writing CTRL with EN=0 clears prescaler, digit index, PWM, frame counter and blink phase at the next edge; outputs blank from that edge.
REQ-023 DATA/BLINK/BRIGHT writes never disturb scan counters; new values appear on pins within one clk of the register update.
REQ-024 Simultaneous register write and slot wrap: both take effect on the same edge; displayed digit uses the new value.

Reset
REQ-025 On reset: DATA=0, CTRL=0x00000F00 (EN=0, HEX=0, BRIGHT=15), BLINK=0, all counters 0, blink phase 0, seg_n=8'hFF, dig_n all ones.
REQ-026 Reset asserted mid-scan overrides any concurrent write and forces REQ-025 values at that edge.

Configuration
REQ-027 Macro LED_SCAN_HEXDEC_EN defined: CTRL.HEX=1 makes pattern = hex-decode of digit byte bits3:0 (0-F standard glyphs) with DP from byte bit7; HEX=0 uses raw byte.
REQ-028 Macro undefined: CTRL.HEX not implemented, reads 0, raw byte always used, decoder not instantiated.

Structure
REQ-029 Package cineraria_led_pkg holds register address constants, CTRL bit positions, reset value and the 16-entry hex glyph table.
REQ-030 Sub-module cineraria_core_led_hex7 (combinational 4-bit -> 7-segment decoder) instantiated only under LED_SCAN_HEXDEC_EN.

Verification (PRESCALE=8, GUARD=1, BLINK_DIV=2, DIGITS=4)
REQ-031 Reset, no writes -> seg_n=FF, dig_n=F, readdata addr1=0x00000F00.
REQ-032 DATA=0x3F065B4F, CTRL=0x0F01 -> dig_n cycles E,D,B,7 every 8 clk with 1 blank clk per slot; seg_n=~0x4F,~0x5B,~0x06,~0x3F.
REQ-033 BRIGHT=3 -> in each active slot region, drive on exactly 4 of every 16 PWM counts.
REQ-034 BLINK=0x2 -> digit 1 blanked during alternate 2-frame periods (64 clk); STATUS bit2 toggles every 64 clk.
REQ-035 With LED_SCAN_HEXDEC_EN, DATA=0x0000810A, CTRL=0x0F03 -> digit0 seg_n=~0x77 ("A"), digit1 seg_n=~0x86 ("1" plus DP).
REQ-036 Write CTRL EN=0 mid-slot, then EN=1 -> outputs blank next edge; scan restarts at digit 0, prescaler 0; STATUS reads 0.
